// File: rtl/latch_bank_pkg.sv
// Shared types for the latch_bank register bank: command opcodes, scan FSM states
// and a small range-check helper used for channel addresses.
package latch_bank_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_WRITE  = 2'd0,
    OP_LOCK   = 2'd1,
    OP_UNLOCK = 2'd2,
    OP_SHIFT  = 2'd3
  } cmd_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } shift_state_e;

  // The address field may be wider than needed when CHANNELS is not a power of two.
  function automatic logic in_range(input int unsigned idx, input int unsigned count);
    return idx < count;
  endfunction

endpackage

// File: rtl/latch_bank_if.sv
// Command handshake bundle for latch_bank: the master issues ops, the bank (slave)
// answers with ready and a one-cycle error pulse.
interface latch_bank_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int ADDR_W   = $clog2(CHANNELS)
);
  import latch_bank_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  cmd_op_e           cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [WIDTH-1:0]  cmd_data;
  logic              cmd_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data,
    input  cmd_ready, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data,
    output cmd_ready, cmd_err
  );

endinterface

// File: rtl/latch_bank_shift_ctrl.sv
// Scan-chain sequencer for latch_bank: walks the whole bank one bit per enabled
// cycle for STEPS cycles after a SHIFT command is accepted.
module latch_bank_shift_ctrl
  import latch_bank_pkg::*;
#(
  parameter int STEPS = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic start,
  output logic busy,
  output logic shift_step
);

  localparam int CNT_W = (STEPS > 2) ? $clog2(STEPS) : 1;

  shift_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values and simulation matches the synthesized hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_step = 1'b0;
    if (ena) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_SHIFT;
            cnt_d   = CNT_W'(STEPS - 1);
          end
        end
        ST_SHIFT: begin
          shift_step = 1'b1;
          if (cnt_q == '0) state_d = ST_IDLE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign busy = (state_q == ST_SHIFT);

endmodule

// File: rtl/latch_bank.sv
// CHANNELS x WIDTH register bank with write lock, registered readback and an
// optional serial scan chain built only when LATCH_BANK_SHIFT_EN is defined.
module latch_bank
  import latch_bank_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int ADDR_W   = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  latch_bank_if.slave         cmd,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [WIDTH-1:0]    rd_data,
  output logic [CHANNELS-1:0] locked,
  input  logic                shift_in,
  output logic                shift_out,
  output logic                busy
);

  localparam int BITS = WIDTH * CHANNELS;

  // Packed so the whole bank can be shifted as one BITS-wide vector.
  typedef logic [CHANNELS-1:0][WIDTH-1:0] bank_t;

  bank_t               bank_q, bank_d;
  logic [CHANNELS-1:0] locked_q, locked_d;
  logic [WIDTH-1:0]    rd_data_q, rd_data_d;
  logic                cmd_err_q, cmd_err_d;
  logic                accept;
  logic                cmd_in_range;
  logic                rd_in_range;

  assign cmd_in_range = in_range(32'(cmd.cmd_addr), CHANNELS);
  assign rd_in_range  = in_range(32'(rd_addr), CHANNELS);
  assign accept       = cmd.cmd_valid && cmd.cmd_ready;

`ifdef LATCH_BANK_SHIFT_EN
  logic shift_start;
  logic shift_step;

  assign shift_start = accept && (cmd.cmd_op == OP_SHIFT);

  latch_bank_shift_ctrl #(
    .STEPS (BITS)
  ) u_shift_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .start      (shift_start),
    .busy       (busy),
    .shift_step (shift_step)
  );

  assign shift_out = bank_q[CHANNELS-1][WIDTH-1];
`else
  logic unused_shift_in;

  assign unused_shift_in = shift_in;
  assign busy            = 1'b0;
  assign shift_out       = 1'b0;
`endif

  assign cmd.cmd_ready = ena && !busy;
  assign cmd.cmd_err   = cmd_err_q;
  assign rd_data       = rd_data_q;
  assign locked        = locked_q;

  always_comb begin
    bank_d    = bank_q;
    locked_d  = locked_q;
    rd_data_d = rd_data_q;
    cmd_err_d = 1'b0;
    if (ena) begin
      rd_data_d = rd_in_range ? bank_q[rd_addr] : '0;
`ifdef LATCH_BANK_SHIFT_EN
      // Locks do not protect against the scan chain; ch0 bit0 is the entry point.
      if (shift_step) bank_d = BITS'({bank_q, shift_in});
`endif
      if (accept) begin
        case (cmd.cmd_op)
          OP_WRITE: begin
            if (cmd_in_range && !locked_q[cmd.cmd_addr]) bank_d[cmd.cmd_addr] = cmd.cmd_data;
            else                                         cmd_err_d            = 1'b1;
          end
          OP_LOCK: begin
            if (cmd_in_range) locked_d[cmd.cmd_addr] = 1'b1;
            else              cmd_err_d              = 1'b1;
          end
          OP_UNLOCK: begin
            if (cmd_in_range) locked_d[cmd.cmd_addr] = 1'b0;
            else              cmd_err_d              = 1'b1;
          end
          OP_SHIFT: begin
`ifndef LATCH_BANK_SHIFT_EN
            cmd_err_d = 1'b1;
`endif
          end
          default: cmd_err_d = 1'b1;
        endcase
      end
    end
  end

  // NOTE: the storage words are ordinary flops with a defined reset value, so
  // they sit in the reset branch like any other state rather than in a RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q    <= '0;
      locked_q  <= '0;
      rd_data_q <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      bank_q    <= bank_d;
      locked_q  <= locked_d;
      rd_data_q <= rd_data_d;
      cmd_err_q <= cmd_err_d;
    end
  end

endmodule
